// File: rtl/slicer_level_adapt.sv
// slicer_level_adapt
// Runtime controller for the PAM4 slicer symbol separation.
// After a start pulse it averages |estimation| over 2^LOG2_ACQ_LEN valid
// samples to acquire an initial separation. It then tracks drift with
// sign-sign voting against the expected inner/outer symbol magnitude.
// Optional build macro SLICER_ADAPT_STATS_EN adds saturating up/down step
// counters on ports up_cnt / dn_cnt.

module slicer_level_adapt #(
    parameter int W            = 16,
    parameter int SEP_W        = 16,
    parameter int INIT_SEP     = 56,
    parameter int LOG2_ACQ_LEN = 4,
    parameter int VOTE_TH      = 8,
    parameter int STEP         = 1,
    parameter int MIN_SEP      = 8,
    parameter int MAX_SEP      = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     estimation,
    input  logic             e_valid,
    input  logic             start,
    input  logic             freeze,
    output logic [SEP_W-1:0] sep_out,
    output logic             sep_upd,
    output logic             acq_done,
    output logic [1:0]       state_o
`ifdef SLICER_ADAPT_STATS_EN
    ,
    output logic [15:0]      up_cnt,
    output logic [15:0]      dn_cnt
`endif
);

    localparam int ACC_W  = W + LOG2_ACQ_LEN;
    localparam int CMP_W  = ((W > SEP_W) ? W : SEP_W) + 3;
    localparam int VOTE_W = $clog2(VOTE_TH) + 2;
    localparam int CNT_W  = LOG2_ACQ_LEN + 1;

    localparam logic [W-1:0]            MOST_NEG  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]            MOST_POS  = {1'b0, {(W-1){1'b1}}};
    localparam logic [CNT_W-1:0]        ACQ_LAST  = CNT_W'((1 << LOG2_ACQ_LEN) - 1);
    localparam logic signed [CMP_W-1:0] MIN_S     = CMP_W'(MIN_SEP);
    localparam logic signed [CMP_W-1:0] MAX_S     = CMP_W'(MAX_SEP);
    localparam logic signed [CMP_W-1:0] STEP_S    = CMP_W'(STEP);
    localparam logic [SEP_W-1:0]        MIN_SEP_V = SEP_W'(MIN_SEP);
    localparam logic [SEP_W-1:0]        MAX_SEP_V = SEP_W'(MAX_SEP);
    localparam logic [SEP_W-1:0]        INIT_V    = SEP_W'(INIT_SEP);
    localparam logic signed [VOTE_W-1:0] VOTE_POS = VOTE_W'(VOTE_TH);
    localparam logic signed [VOTE_W-1:0] VOTE_NEG = VOTE_W'(-VOTE_TH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                    stateQ, stateD;
    logic [SEP_W-1:0]          sepQ, sepD;
    logic [ACC_W-1:0]          accQ, accD;
    logic [CNT_W-1:0]          cntQ, cntD;
    logic signed [VOTE_W-1:0]  voteQ, voteD;
    logic                      updQ, updD;
    logic                      doneQ, doneD;
`ifdef SLICER_ADAPT_STATS_EN
    logic [15:0]               upCntQ, upCntD;
    logic [15:0]               dnCntQ, dnCntD;
`endif

    logic [W-1:0]              absX;
    logic [ACC_W-1:0]          accSum;
    logic signed [CMP_W-1:0]   meanS;
    logic signed [CMP_W-1:0]   sepS;
    logic signed [CMP_W-1:0]   absS;
    logic signed [CMP_W-1:0]   halfS;
    logic signed [CMP_W-1:0]   expS;
    logic signed [CMP_W-1:0]   errS;
    logic signed [CMP_W-1:0]   upS;
    logic signed [CMP_W-1:0]   dnS;
    logic signed [VOTE_W-1:0]  voteStep;
    logic signed [VOTE_W-1:0]  voteSum;
    logic [SEP_W-1:0]          acqSep;
    logic [SEP_W-1:0]          sepUp;
    logic [SEP_W-1:0]          sepDn;

    // Magnitude of the sample; the most-negative code saturates to the largest positive value
    always_comb begin
        absX = estimation;
        if (estimation == MOST_NEG) begin
            absX = MOST_POS;
        end else if (estimation[W-1]) begin
            absX = -estimation;
        end
    end

    // Datapath shared by acquisition and tracking: mean, expected level, error, vote and clamped steps
    always_comb begin
        accSum   = accQ + ACC_W'(absX);
        meanS    = $signed(CMP_W'(accSum[ACC_W-1:LOG2_ACQ_LEN]));
        sepS     = $signed(CMP_W'(sepQ));
        absS     = $signed(CMP_W'(absX));
        halfS    = sepS >>> 1;
        expS     = (absS >= sepS) ? (sepS + halfS) : halfS;
        errS     = absS - expS;
        voteStep = '0;
        if (errS[CMP_W-1]) begin
            voteStep = VOTE_W'(-1);
        end else if (errS != '0) begin
            voteStep = VOTE_W'(1);
        end
        voteSum  = voteQ + voteStep;
        upS      = sepS + STEP_S;
        dnS      = sepS - STEP_S;
        sepUp    = (upS > MAX_S) ? MAX_SEP_V : upS[SEP_W-1:0];
        sepDn    = (dnS < MIN_S) ? MIN_SEP_V : dnS[SEP_W-1:0];
        if (meanS < MIN_S) begin
            acqSep = MIN_SEP_V;
        end else if (meanS > MAX_S) begin
            acqSep = MAX_SEP_V;
        end else begin
            acqSep = meanS[SEP_W-1:0];
        end
    end

    // Next-state logic: start overrides everything, then per-state acquisition / tracking / hold behaviour
    always_comb begin
        stateD = stateQ;
        sepD   = sepQ;
        accD   = accQ;
        cntD   = cntQ;
        voteD  = voteQ;
        updD   = 1'b0;
        doneD  = 1'b0;
`ifdef SLICER_ADAPT_STATS_EN
        upCntD = upCntQ;
        dnCntD = dnCntQ;
`endif
        if (start) begin
            accD   = '0;
            cntD   = '0;
            voteD  = '0;
            stateD = ACQ;
`ifdef SLICER_ADAPT_STATS_EN
            upCntD = '0;
            dnCntD = '0;
`endif
        end else begin
            case (stateQ)
                IDLE: begin
                end
                ACQ: begin
                    if (e_valid) begin
                        accD = accSum;
                        cntD = cntQ + CNT_W'(1);
                        if (cntQ == ACQ_LAST) begin
                            sepD   = acqSep;
                            doneD  = 1'b1;
                            updD   = 1'b1;
                            accD   = '0;
                            cntD   = '0;
                            stateD = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (freeze) begin
                        stateD = HOLD;
                    end else if (e_valid) begin
                        if (voteSum == VOTE_POS) begin
                            voteD = '0;
                            sepD  = sepUp;
                            updD  = (sepUp != sepQ);
`ifdef SLICER_ADAPT_STATS_EN
                            if (upCntQ != 16'hFFFF) begin
                                upCntD = upCntQ + 16'd1;
                            end
`endif
                        end else if (voteSum == VOTE_NEG) begin
                            voteD = '0;
                            sepD  = sepDn;
                            updD  = (sepDn != sepQ);
`ifdef SLICER_ADAPT_STATS_EN
                            if (dnCntQ != 16'hFFFF) begin
                                dnCntD = dnCntQ + 16'd1;
                            end
`endif
                        end else begin
                            voteD = voteSum;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        stateD = TRACK;
                    end
                end
                default: begin
                    stateD = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority over start
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            sepQ   <= INIT_V;
            accQ   <= '0;
            cntQ   <= '0;
            voteQ  <= '0;
            updQ   <= 1'b0;
            doneQ  <= 1'b0;
`ifdef SLICER_ADAPT_STATS_EN
            upCntQ <= '0;
            dnCntQ <= '0;
`endif
        end else begin
            stateQ <= stateD;
            sepQ   <= sepD;
            accQ   <= accD;
            cntQ   <= cntD;
            voteQ  <= voteD;
            updQ   <= updD;
            doneQ  <= doneD;
`ifdef SLICER_ADAPT_STATS_EN
            upCntQ <= upCntD;
            dnCntQ <= dnCntD;
`endif
        end
    end

    assign sep_out  = sepQ;
    assign sep_upd  = updQ;
    assign acq_done = doneQ;
    assign state_o  = stateQ;
`ifdef SLICER_ADAPT_STATS_EN
    assign up_cnt   = upCntQ;
    assign dn_cnt   = dnCntQ;
`endif

endmodule

// File: doc/slicer_level_adapt.md
Name: slicer_level_adapt

Overview:
- Runtime controller that configures the PAM4 slicer's symbol separation instead of leaving it as a fixed elaboration constant.
- Sits beside the decision slicer in the Rx DFE path and watches the same equalized estimation stream.
- Acquires an initial separation by averaging |estimation|, then tracks drift with sign-sign voting.
- Drives sep_out into the slicer's threshold/level logic.

Parameters:
- W, 16, signed width of estimation.
- SEP_W, 16, unsigned width of sep_out.
- INIT_SEP, 56, separation driven from reset/IDLE.
- LOG2_ACQ_LEN, 4, acquisition length = 2^LOG2_ACQ_LEN valid samples.
- VOTE_TH, 8, vote magnitude that triggers a tracking step.
- STEP, 1, separation increment/decrement per step.
- MIN_SEP, 8, lower clamp.
- MAX_SEP, 1024, upper clamp.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- estimation  in  W  signed equalized sample
- e_valid  in  1  estimation qualifier
- start  in  1  pulse; (re)start acquisition
- freeze  in  1  level; hold tracking
- sep_out  out  SEP_W  separation to slicer
- sep_upd  out  1  1-cycle pulse when sep_out changes value or is reloaded
- acq_done  out  1  1-cycle pulse at end of acquisition
- state_o  out  2  IDLE=0, ACQ=1, TRACK=2, HOLD=3

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: sep_out=INIT_SEP, state IDLE, all pulses 0, accumulator/sample count/vote counter 0.
- |x| is computed on estimation. The most-negative input saturates to 2^(W-1)-1.
- IDLE: ignores samples. start -> ACQ.
- ACQ:
  - Each e_valid adds |x| to an accumulator of W+LOG2_ACQ_LEN bits and increments the sample count.
  - On the 2^LOG2_ACQ_LEN-th valid sample, on the next edge: sep_out = clamp(sum >> LOG2_ACQ_LEN), acq_done=1, sep_upd=1, state -> TRACK.
  - sep_upd pulses here even if the value is unchanged.
  - Rationale: mean |x| of equiprobable ±S/2, ±3S/2 equals S.
- TRACK, per e_valid sample, with the current sep:
  - If |x| >= sep: expected = sep + (sep>>1); else expected = sep>>1.
  - err = |x| - expected. err>0 votes +1, err<0 votes -1, err=0 casts no vote.
  - The vote counter is signed, sized for ±VOTE_TH.
  - When the counter would reach +VOTE_TH: sep_out = min(sep+STEP, MAX_SEP), counter cleared.
  - When it would reach -VOTE_TH: sep_out = max(sep-STEP, MIN_SEP), counter cleared.
  - sep_upd pulses only if the value actually changes. A clamped step clears the counter with no pulse.
  - Latency: sep_out changes on the edge following the deciding sample. The next sample uses the new sep.
- HOLD:
  - freeze=1 in TRACK -> HOLD. Samples are ignored; sep_out and the vote counter are retained.
  - freeze=0 -> TRACK.
  - freeze is ignored in IDLE and ACQ.
- start in any state:
  - Clears the accumulator, sample count and vote counter, state -> ACQ.
  - sep_out keeps its current value until acquisition completes.
  - start takes priority over e_valid and freeze in the same cycle; that cycle's sample is not accumulated.
- rst mid-operation returns everything to reset values on that edge. rst beats start.
- Clamp applies to the acquisition result as well.
- The pulse outputs are never asserted in the same cycle as rst.

Optional Feature:
- Macro SLICER_ADAPT_STATS_EN.
- Defined:
  - Adds outputs up_cnt and dn_cnt, 16 bits each, saturating.
  - They count applied steps in each direction, including clamped attempts.
  - Both clear on rst and on start.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then no stimulus -> sep_out=56, state_o=0, sep_upd=acq_done=0 for 20 cycles, even with e_valid toggling.
2. start, then 16 valid samples cycling +32,-32,+96,-96 (sum|x|=1024) -> one cycle after the 16th: sep_out=64, acq_done=1, sep_upd=1, state_o=2.
3. From sep=64 in TRACK, 8 samples of +100 (outer, err=+4) -> sep_out=65 with sep_upd one cycle after the 8th. Then 8 samples of -96 at sep=65 (expected 97, err=-1) -> sep_out=64.
4. Acquire with 16 samples of value 4 (sep clamps to MIN 8). Then 8 samples of 0 (inner, err=-4) -> sep_out stays 8, no sep_upd pulse, counter cleared; if stats enabled, dn_cnt=1.
5. TRACK at sep=64, 5 samples of +100, then freeze=1 with 10 samples of +100 -> no change, state_o=3. Then freeze=0 and 3 samples of +100 -> sep_out=65 after the 3rd.
6. During ACQ, after 10 samples, pulse start -> count restarts, no acq_done until 16 further valid samples. A separate run asserts rst mid-ACQ -> sep_out=56, state_o=0.
